dma_bus_responder: RTL and testbench

//  Bus target for the DMA custom-instruction initiator: word-addressed SRAM-backed responder for single and burst reads/writes.

---
 rtl/dma_bus_responder_if.sv | 27 ++
 rtl/dma_bus_responder.sv | 120 ++++++++++++
 tb/tb_dma_bus_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_bus_responder_if.sv
// Shared address/data bus between the DMA initiator and the SRAM-backed responder.
interface dma_bus_responder_if;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic        readNotWriteIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busyIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;

  modport master (
    output beginTransactionIn, addressDataIn, readNotWriteIn, byteEnablesIn,
           burstSizeIn, dataValidIn, endTransactionIn, busyIn,
    input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut
  );

  modport slave (
    input  beginTransactionIn, addressDataIn, readNotWriteIn, byteEnablesIn,
           burstSizeIn, dataValidIn, endTransactionIn, busyIn,
    output addressDataOut, dataValidOut, endTransactionOut, busErrorOut
  );
endinterface

// File: rtl/dma_bus_responder.sv
// Word-addressed SRAM bus target: single/burst reads and writes with byte
// enables, address-window decode, misalignment error and initiator stall.
module dma_bus_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          ADDR_BITS    = 10
) (
  input  logic              clock,
  input  logic              reset,
  dma_bus_responder_if.slave bus
);

  localparam int                   DATA_W = 32;
  localparam int                   DEPTH  = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ONE    = 1;

  typedef enum logic [2:0] {IDLE, READ_WAIT, READ_BURST, READ_END, WRITE, ERROR} state_t;

  state_t                state, stateNext;
  logic [DATA_W-1:0]     mem [0:DEPTH-1];
  logic [ADDR_BITS-1:0]  wordAddr;
  logic [8:0]            beatsLeft;
  logic [3:0]            byteEn;
  logic [DATA_W-1:0]     rdWord_p0;
  logic [DATA_W-1:0]     rdWord_p1;
  logic                  vld_p1;

  logic selected, misaligned, beginAccepted;
  logic readAccept, loadBeat, writeBeat;

  assign selected      = (bus.addressDataIn[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);
  assign misaligned    = (bus.addressDataIn[1:0] != 2'b00);
  assign beginAccepted = (state == IDLE) && bus.beginTransactionIn && selected && !misaligned;
  assign readAccept    = vld_p1 && !bus.busyIn;
  // Load the output stage on entry to the burst, or on acceptance when more beats remain.
  assign loadBeat      = (state == READ_BURST) && (!vld_p1 || (readAccept && (beatsLeft != 9'd0)));
  assign writeBeat     = (state == WRITE) && bus.dataValidIn && (beatsLeft != 9'd0);

  assign bus.addressDataOut    = vld_p1 ? rdWord_p1 : '0;
  assign bus.dataValidOut      = vld_p1;
  assign bus.endTransactionOut = (state == READ_END);
  assign bus.busErrorOut       = (state == ERROR);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.beginTransactionIn && selected) begin
          if (misaligned)              stateNext = ERROR;
          else if (bus.readNotWriteIn) stateNext = READ_WAIT;
          else                         stateNext = WRITE;
        end
      end
      READ_WAIT:  stateNext = READ_BURST;
      READ_BURST: if (readAccept && (beatsLeft == 9'd0)) stateNext = READ_END;
      READ_END:   stateNext = IDLE;
      WRITE:      if (bus.endTransactionIn) stateNext = IDLE;
      ERROR:      stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

  // Control: word pointer, beat counter and output-valid flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wordAddr  <= '0;
      beatsLeft <= '0;
      vld_p1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beginAccepted) begin
            wordAddr  <= bus.addressDataIn[ADDR_BITS+1:2];
            // Reads count beats still to present after the current one; writes count beats still allowed.
            beatsLeft <= bus.readNotWriteIn ? {1'b0, bus.burstSizeIn}
                                            : {1'b0, bus.burstSizeIn} + 9'd1;
          end
        end
        READ_WAIT: wordAddr <= wordAddr + ONE;
        READ_BURST: begin
          if (loadBeat) begin
            vld_p1   <= 1'b1;
            wordAddr <= wordAddr + ONE;
            if (vld_p1) beatsLeft <= beatsLeft - 9'd1;
          end else if (readAccept) begin
            vld_p1 <= 1'b0;
          end
        end
        WRITE: begin
          if (writeBeat) begin
            wordAddr  <= wordAddr + ONE;
            beatsLeft <= beatsLeft - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: SRAM array, prefetch stage _p0 and output stage _p1.
  always_ff @(posedge clock) begin
    if (beginAccepted) byteEn <= bus.byteEnablesIn;
    // Stage p0: synchronous SRAM read, one word ahead of the output stage.
    if ((state == READ_WAIT) || loadBeat) rdWord_p0 <= mem[wordAddr];
    // Stage p1: beat presented on the bus, held while the initiator is busy.
    if (loadBeat) rdWord_p1 <= rdWord_p0;
    if (writeBeat) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordAddr][8*i +: 8] <= bus.addressDataIn[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dma_bus_responder.sv
// Directed bench for dma_bus_responder: writes, reads, stalls, decode, wrap, reset abort.
module tb_dma_bus_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;

  dma_bus_responder_if bus();

  dma_bus_responder #(.BASE_ADDRESS(32'h0000_0000), .ADDR_BITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] wrData [0:15];
  logic [31:0] rdBeats [0:15];
  int          rdCount, rdEnds, rdHold, rdFirst, rdEndCycle, rdHoldBad, rdZeroBad;
  logic        rdTimeout;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idleInputs();
    bus.beginTransactionIn = 1'b0;
    bus.addressDataIn      = '0;
    bus.readNotWriteIn     = 1'b0;
    bus.byteEnablesIn      = '0;
    bus.burstSizeIn        = '0;
    bus.dataValidIn        = 1'b0;
    bus.endTransactionIn   = 1'b0;
    bus.busyIn             = 1'b0;
  endtask

  // Write burst: begin pulse, then nBeats data beats with end on the last one.
  task automatic doWrite(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] burst, input int nBeats);
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = addr;
    bus.readNotWriteIn     = 1'b0;
    bus.byteEnablesIn      = be;
    bus.burstSizeIn        = burst;
    tick();
    bus.beginTransactionIn = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      bus.dataValidIn      = 1'b1;
      bus.addressDataIn    = wrData[i];
      bus.endTransactionIn = (i == nBeats - 1);
      tick();
    end
    idleInputs();
  endtask

  // Read burst collector: busyIn held for busyLen cycles when beat busyBeat first appears.
  task automatic doRead(input logic [31:0] addr, input logic [7:0] burst, input int busyBeat, input int busyLen);
    int busyRem;
    int after;
    logic [31:0] holdVal;
    busyRem = busyLen; after = 0;
    rdCount = 0; rdEnds = 0; rdHold = 0; rdFirst = 0; rdEndCycle = 0;
    rdHoldBad = 0; rdZeroBad = 0; rdTimeout = 1'b1; holdVal = '0;
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = addr;
    bus.readNotWriteIn     = 1'b1;
    bus.byteEnablesIn      = 4'hF;
    bus.burstSizeIn        = burst;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      tick();
      if (cyc == 1) idleInputs();
      if (!bus.dataValidOut && bus.addressDataOut !== 32'h0) rdZeroBad++;
      if (bus.endTransactionOut) begin
        rdEnds++;
        if (rdEndCycle == 0) rdEndCycle = cyc;
      end
      if (bus.dataValidOut) begin
        if (rdFirst == 0) rdFirst = cyc;
        if (rdCount == busyBeat) begin
          if (rdHold == 0) holdVal = bus.addressDataOut;
          else if (bus.addressDataOut !== holdVal) rdHoldBad++;
          rdHold++;
        end
        if (rdCount == busyBeat && busyRem > 0) begin
          bus.busyIn = 1'b1;
          busyRem--;
        end else begin
          bus.busyIn = 1'b0;
          if (rdCount < 16) rdBeats[rdCount] = bus.addressDataOut;
          rdCount++;
        end
      end else begin
        bus.busyIn = 1'b0;
      end
      if (rdEnds > 0) begin
        after++;
        if (after > 2) begin
          rdTimeout = 1'b0;
          break;
        end
      end
    end
    idleInputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    repeat (3) tick();
    checks++;
    if (bus.dataValidOut !== 1'b0 || bus.addressDataOut !== 32'h0) $display("FAIL reset_data: dv=%b data=%h required dv=0 data=0", bus.dataValidOut, bus.addressDataOut);
    else passes++;
    checks++;
    if (bus.endTransactionOut !== 1'b0) $display("FAIL reset_end: got %b required 0", bus.endTransactionOut);
    else passes++;
    checks++;
    if (bus.busErrorOut !== 1'b0) $display("FAIL reset_err: got %b required 0", bus.busErrorOut);
    else passes++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    wrData[0] = 32'hDEADBEEF;
    doWrite(32'h10, 4'hF, 8'd0, 1);
    doRead(32'h10, 8'd0, -1, 0);
    checks++;
    if (rdTimeout !== 1'b0) $display("FAIL single_timeout: got timeout=%b required 0", rdTimeout);
    else passes++;
    checks++;
    if (rdFirst != 3) $display("FAIL single_latency: first beat at cycle %0d required 3", rdFirst);
    else passes++;
    checks++;
    if (rdCount != 1 || rdBeats[0] !== 32'hDEADBEEF) $display("FAIL single_data: count=%0d data=%h required 1 deadbeef", rdCount, rdBeats[0]);
    else passes++;
    checks++;
    if (rdEnds != 1 || rdEndCycle != 4) $display("FAIL single_end: ends=%0d at %0d required 1 at 4", rdEnds, rdEndCycle);
    else passes++;
    checks++;
    if (rdZeroBad != 0) $display("FAIL single_zero: %0d nonzero idle cycles required 0", rdZeroBad);
    else passes++;
  endtask

  task automatic test_byte_enable();
    wrData[0] = 32'h11223344;
    doWrite(32'h10, 4'b0101, 8'd0, 1);
    doRead(32'h10, 8'd0, -1, 0);
    checks++;
    if (rdCount != 1 || rdBeats[0] !== 32'hDE22BE44) $display("FAIL byte_enable: count=%0d data=%h required 1 de22be44", rdCount, rdBeats[0]);
    else passes++;
  endtask

  task automatic test_burst_busy();
    for (int i = 0; i < 4; i++) wrData[i] = i + 1;
    doWrite(32'h20, 4'hF, 8'd3, 4);
    doRead(32'h20, 8'd3, 1, 2);
    checks++;
    if (rdTimeout !== 1'b0 || rdCount != 4) $display("FAIL burst_count: timeout=%b count=%0d required 0 4", rdTimeout, rdCount);
    else passes++;
    checks++;
    if (rdBeats[0] !== 32'd1 || rdBeats[1] !== 32'd2 || rdBeats[2] !== 32'd3 || rdBeats[3] !== 32'd4)
      $display("FAIL burst_data: got %h %h %h %h required 1 2 3 4", rdBeats[0], rdBeats[1], rdBeats[2], rdBeats[3]);
    else passes++;
    checks++;
    if (rdHold != 3 || rdHoldBad != 0) $display("FAIL burst_stall: held %0d cycles (%0d changes) required 3 (0)", rdHold, rdHoldBad);
    else passes++;
    checks++;
    if (rdEnds != 1 || rdZeroBad != 0) $display("FAIL burst_end: ends=%0d zeroBad=%0d required 1 0", rdEnds, rdZeroBad);
    else passes++;
  endtask

  task automatic test_window();
    int viol;
    int errCycles;
    viol = 0;
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = 32'h0000_1000;
    bus.readNotWriteIn     = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      idleInputs();
      if (bus.dataValidOut || bus.endTransactionOut || bus.busErrorOut || bus.addressDataOut !== 32'h0) viol++;
    end
    checks++;
    if (viol != 0) $display("FAIL window_outside: %0d active cycles required 0", viol);
    else passes++;
    errCycles = 0;
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = 32'h12;
    bus.readNotWriteIn     = 1'b0;
    bus.byteEnablesIn      = 4'hF;
    tick();
    bus.beginTransactionIn = 1'b0;
    bus.dataValidIn        = 1'b1;
    bus.endTransactionIn   = 1'b1;
    bus.addressDataIn      = 32'hFFFFFFFF;
    checks++;
    if (bus.busErrorOut !== 1'b1) $display("FAIL misaligned_err: got %b required 1", bus.busErrorOut);
    else passes++;
    for (int c = 0; c < 4; c++) begin
      tick();
      idleInputs();
      if (bus.busErrorOut || bus.dataValidOut) errCycles++;
    end
    checks++;
    if (errCycles != 0) $display("FAIL misaligned_pulse: %0d extra active cycles required 0", errCycles);
    else passes++;
    doRead(32'h10, 8'd0, -1, 0);
    checks++;
    if (rdBeats[0] !== 32'hDE22BE44) $display("FAIL misaligned_nowrite: got %h required de22be44", rdBeats[0]);
    else passes++;
  endtask

  task automatic test_wrap();
    wrData[0] = 32'hA;
    doWrite(32'hFFC, 4'hF, 8'd0, 1);
    wrData[0] = 32'hB;
    doWrite(32'h0, 4'hF, 8'd0, 1);
    doRead(32'hFFC, 8'd1, -1, 0);
    checks++;
    if (rdCount != 2 || rdBeats[0] !== 32'hA || rdBeats[1] !== 32'hB)
      $display("FAIL wrap: count=%0d data=%h %h required 2 a b", rdCount, rdBeats[0], rdBeats[1]);
    else passes++;
  endtask

  task automatic test_reset_abort();
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = 32'h20;
    bus.readNotWriteIn     = 1'b1;
    bus.burstSizeIn        = 8'd7;
    for (int c = 1; c <= 5; c++) begin
      tick();
      idleInputs();
    end
    checks++;
    if (bus.dataValidOut !== 1'b1 || bus.addressDataOut !== 32'd3) $display("FAIL abort_beat2: dv=%b data=%h required 1 3", bus.dataValidOut, bus.addressDataOut);
    else passes++;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.dataValidOut || bus.endTransactionOut || bus.busErrorOut || bus.addressDataOut !== 32'h0)
      $display("FAIL abort_outputs: dv=%b end=%b err=%b data=%h required all 0", bus.dataValidOut, bus.endTransactionOut, bus.busErrorOut, bus.addressDataOut);
    else passes++;
    reset = 1'b0;
    doRead(32'h10, 8'd0, -1, 0);
    checks++;
    if (rdFirst != 3 || rdCount != 1 || rdBeats[0] !== 32'hDE22BE44 || rdEnds != 1)
      $display("FAIL abort_newread: first=%0d count=%0d data=%h ends=%0d required 3 1 de22be44 1", rdFirst, rdCount, rdBeats[0], rdEnds);
    else passes++;
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_single();
    test_byte_enable();
    test_burst_busy();
    test_window();
    test_wrap();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
